// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency sprite ROM among NUM_REQ drawers.
// Define SPRITE_ARB_BURST_EN to let a requester keep the ROM for up to BURST_LEN consecutive grants.
module sprite_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 3,
    parameter int ROM_DEPTH = 1024,
    parameter int BURST_LEN = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);
    localparam int          PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] DEPTH_L = 32'(ROM_DEPTH);

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    function automatic logic [DATA_W-1:0] mask_oor(input logic live, input logic oor,
                                                   input logic [DATA_W-1:0] d);
        return (live && !oor) ? d : '0;
    endfunction

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] rsp_sel_q, rsp_sel_d;
    logic               oor_q, oor_d;
    logic               rr_vld, win_vld;
    logic [PTR_W-1:0]   rr_idx, win_idx, cand;
    logic [ADDR_W-1:0]  win_addr;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_inc(ptr_q, k);
            if (!rr_vld && req[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
    end

`ifdef SPRITE_ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [PTR_W-1:0] last_idx_q, last_idx_d;
    logic             burst_hold;

    // Last cycle's winner keeps the ROM while it still requests and has burst budget left
    assign burst_hold = (|rsp_sel_q) && req[last_idx_q] &&
                        (burst_cnt_q < CNT_W'(BURST_LEN - 1));

    always_comb begin
        win_vld     = burst_hold || rr_vld;
        win_idx     = burst_hold ? last_idx_q : rr_idx;
        burst_cnt_d = burst_hold ? burst_cnt_q + 1'b1 : '0;
        last_idx_d  = win_vld ? win_idx : last_idx_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            burst_cnt_q <= '0;
            last_idx_q  <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            last_idx_q  <= last_idx_d;
        end
    end
`else
    logic unused_burst_len;
    assign unused_burst_len = (BURST_LEN > 0);

    always_comb begin
        win_vld = rr_vld;
        win_idx = rr_idx;
    end
`endif

    // Request cycle: one-hot grant and ROM address, both silenced during reset
    always_comb begin
        win_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        gnt      = '0;
        rom_addr = '0;
        if (win_vld && !Reset) begin
            gnt[win_idx] = 1'b1;
            rom_addr     = win_addr;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) ptr_d = wrap_inc(win_idx, 1);
        rsp_sel_d = gnt;
        oor_d     = (32'(rom_addr) >= DEPTH_L);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q     <= '0;
            rsp_sel_q <= '0;
            oor_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_sel_q <= rsp_sel_d;
            oor_q     <= oor_d;
        end
    end

    // Response cycle: ROM data tagged to last cycle's winner, zeroed for out-of-range reads
    assign rsp_valid = rsp_sel_q;
    assign rsp_data  = mask_oor(|rsp_sel_q, oor_q, rom_data);

endmodule
